// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM state encoding, error codes and default start-of-frame marker
package uart_frame_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;
  localparam logic [7:0] SOF_DEFAULT = 8'hAA;
endpackage

// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer: DEPTH x 8 payload register file, synchronous write, asynchronous read
module uart_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= wr_data;
  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: SOF/LEN/payload/CHK framer with valid/ready replay; inter-byte timeout under UART_FRAME_TIMEOUT_EN
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int MAX_PAYLOAD = 16,
  parameter int TIMEOUT_CLKS = 1740
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data,
  output logic       o_Data_Last,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun,
  output logic       o_Busy
);
  localparam int IW = $clog2(MAX_PAYLOAD);
  localparam logic [7:0] MAX8 = 8'(MAX_PAYLOAD);
  state_t state, nxt;
  logic [1:0] err;
  logic [7:0] sum, chk_sum, rd_data;
  logic [IW-1:0] len_m1, wr_idx, rd_idx;
  logic take, last, to_hit;
  assign chk_sum = sum + i_Rx_Byte;
  assign last = rd_idx == len_m1;
  assign take = o_Data_Valid && i_Data_Ready;
  uart_frame_buffer #(.DEPTH(MAX_PAYLOAD)) u_buf (
    .clk(i_Clock),
    .wr_en(state == S_PAYLOAD && i_Rx_DV),
    .wr_idx(wr_idx),
    .wr_data(i_Rx_Byte),
    .rd_idx(rd_idx),
    .rd_data(rd_data)
  );
`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] to_cnt;
  logic timing;
  assign timing = state == S_LEN || state == S_PAYLOAD || state == S_CHK;
  // an arriving byte on the final count takes priority over the timeout
  assign to_hit = timing && !i_Rx_DV && to_cnt == TO_LAST;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) to_cnt <= '0;
    else to_cnt <= (!timing || i_Rx_DV || nxt != state) ? '0 : to_cnt + 16'd1;
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    err = ERR_NONE;
    case (state)
      S_IDLE: nxt = (i_Rx_DV && i_Rx_Byte == SOF_BYTE) ? S_LEN : S_IDLE;
      S_LEN:
        if (i_Rx_DV) begin
          nxt = (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX8) ? S_IDLE : S_PAYLOAD;
          err = (nxt == S_IDLE) ? ERR_LEN : ERR_NONE;
        end
      S_PAYLOAD: nxt = (i_Rx_DV && wr_idx == len_m1) ? S_CHK : S_PAYLOAD;
      S_CHK:
        if (i_Rx_DV) begin
          nxt = (chk_sum == 8'd0) ? S_DRAIN : S_IDLE;
          err = (chk_sum == 8'd0) ? ERR_NONE : ERR_CHK;
        end
      S_DRAIN: nxt = (take && last) ? S_IDLE : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
    if (to_hit) begin
      nxt = S_IDLE;
      err = ERR_TIMEOUT;
    end
  end
  always_comb begin
    o_Data_Valid = state == S_DRAIN;
    o_Data = o_Data_Valid ? rd_data : 8'd0;
    o_Data_Last = o_Data_Valid && last;
    o_Busy = state != S_IDLE;
  end
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      sum <= '0;
      len_m1 <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      o_Frame_Err <= 1'b0;
      o_Err_Code <= ERR_NONE;
      o_Overrun <= 1'b0;
    end else begin
      o_Frame_Err <= err != ERR_NONE;
      if (err != ERR_NONE) o_Err_Code <= err;
      o_Overrun <= state == S_DRAIN && i_Rx_DV;
      if (state == S_LEN && nxt == S_PAYLOAD) begin
        sum <= i_Rx_Byte;
        len_m1 <= IW'(i_Rx_Byte - 8'd1);
        wr_idx <= '0;
      end
      if (state == S_PAYLOAD && i_Rx_DV) begin
        sum <= chk_sum;
        wr_idx <= wr_idx + 1'b1;
      end
      if (state == S_CHK && nxt == S_DRAIN) rd_idx <= '0;
      if (take) rd_idx <= rd_idx + 1'b1;
    end
endmodule
